// File: rtl/dff_pkg.sv
// Shared types and constants for the dff_pipe register slice and its stage cell.
package dff_pkg;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;
    localparam int DEPTH_MIN = 1;
    localparam int DEPTH_MAX = 16;

    // Data field is sized for the widest legal slice; narrower stages zero-extend.
    typedef struct packed {
        logic [WIDTH_MAX-1:0] data;
        logic                 valid;
    } stage_t;

    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_stage.sv
// One dff_pipe stage: WIDTH data bits plus a valid bit, with stall hold.
// With DFF_PIPE_SCAN_EN defined the data bits also form a serial scan segment.
module dff_stage
    import dff_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             SE,
    input  logic [WIDTH-1:0] D,
    input  logic             VALID_IN,
    input  logic             SI,
    output logic [WIDTH-1:0] Q,
    output logic             VALID_OUT,
    output logic             SO
);

    stage_t r;

`ifdef DFF_PIPE_SCAN_EN
    logic [WIDTH-1:0] shifted;

    // SI enters bit 0; the old MSB leaves through SO toward the next stage.
    assign shifted = WIDTH'({r.data[WIDTH-1:0], SI});
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r <= '0;
`ifdef DFF_PIPE_SCAN_EN
        end else if (SE) begin
            r.data <= WIDTH_MAX'(shifted);
`endif
        end else if (EN) begin
            r.data  <= WIDTH_MAX'(D);
            r.valid <= VALID_IN;
        end
    end

    assign Q         = r.data[WIDTH-1:0];
    assign VALID_OUT = r.valid;

`ifdef DFF_PIPE_SCAN_EN
    assign SO = r.data[WIDTH-1];
`else
    logic unused_scan;
    assign unused_scan = SE ^ SI;
    assign SO          = 1'b0;
`endif

    // Bits above WIDTH are always zero and exist only because of the shared struct.
    logic unused_hi;
    assign unused_hi = |(r.data >> WIDTH);

endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH x DEPTH register slice with per-stage valid, stall and COUNT.
// Define DFF_PIPE_SCAN_EN to chain every data bit into one scan path SI -> SO.
module dff_pipe
    import dff_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      EN,
    input  logic [WIDTH-1:0]          D,
    input  logic                      VALID_IN,
    output logic [WIDTH-1:0]          Q,
    output logic                      VALID_OUT,
    output logic [count_w(DEPTH)-1:0] COUNT,
    input  logic                      SE,
    input  logic                      SI,
    output logic                      SO
);

    localparam int CW = count_w(DEPTH);

    logic [DEPTH:0][WIDTH-1:0] data_chain;
    logic [DEPTH:0]            vld_chain;
    logic [DEPTH:0]            scan_chain;
    logic                      advance;

    assign data_chain[0] = D;
    assign vld_chain[0]  = VALID_IN;
    assign scan_chain[0] = SI;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        dff_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .CLK      (CLK),
            .RST      (RST),
            .EN       (EN),
            .SE       (SE),
            .D        (data_chain[k]),
            .VALID_IN (vld_chain[k]),
            .SI       (scan_chain[k]),
            .Q        (data_chain[k+1]),
            .VALID_OUT(vld_chain[k+1]),
            .SO       (scan_chain[k+1])
        );
    end

    assign Q         = data_chain[DEPTH];
    assign VALID_OUT = vld_chain[DEPTH];
    assign SO        = scan_chain[DEPTH];

`ifdef DFF_PIPE_SCAN_EN
    assign advance = EN && !SE;
`else
    assign advance = EN;
`endif

    // Occupancy tracks the valid word entering against the one leaving the last stage.
    always_ff @(posedge CLK) begin
        if (RST) begin
            COUNT <= '0;
        end else if (advance) begin
            if (VALID_IN && !VALID_OUT) begin
                COUNT <= COUNT + CW'(1);
            end else if (!VALID_IN && VALID_OUT) begin
                COUNT <= COUNT - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_dff_pipe.sv
// Scoreboard bench for dff_pipe (WIDTH=8, DEPTH=3); follows DFF_PIPE_SCAN_EN if defined.
`timescale 1ns/1ps
module tb_dff_pipe;
    import dff_pkg::*;

    localparam int W     = 8;
    localparam int DEPTH = 3;
    localparam int CW    = count_w(DEPTH);
`ifdef DFF_PIPE_SCAN_EN
    localparam bit SCAN = 1'b1;
`else
    localparam bit SCAN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, en, vin, se, si;
    logic [W-1:0]  d;
    logic [W-1:0]  q;
    logic          vout, so;
    logic [CW-1:0] count;

    dff_pipe #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .CLK(clk), .RST(rst), .EN(en), .D(d), .VALID_IN(vin),
        .Q(q), .VALID_OUT(vout), .COUNT(count),
        .SE(se), .SI(si), .SO(so)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        int           arrive;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] dq[DEPTH];
    bit           vq[DEPTH];
    int           adv_cnt  = 0;
    bit           last_adv = 1'b0;
    bit           chk      = 1'b0;
    int           n_chk    = 0;
    int           n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Drive one cycle, then advance the reference model for that edge.
    task automatic cyc(input logic r, input logic e, input logic v, input logic [W-1:0] dd,
                       input logic s, input logic sv);
        rst = r; en = e; vin = v; d = dd; se = s; si = sv;
        @(posedge clk);
        if (r) begin
            sb.delete();
            for (int k = 0; k < DEPTH; k++) begin
                dq[k] = '0;
                vq[k] = 1'b0;
            end
            last_adv = 1'b0;
        end else if (SCAN && s) begin
            for (int k = DEPTH - 1; k > 0; k--) dq[k] = {dq[k][W-2:0], dq[k-1][W-1]};
            dq[0] = {dq[0][W-2:0], sv};
            foreach (sb[i]) begin
                int p;
                p = DEPTH - 1 - (sb[i].arrive - adv_cnt);
                if (p >= 0 && p < DEPTH) sb[i].data = dq[p];
            end
            last_adv = 1'b0;
        end else if (e) begin
            adv_cnt++;
            for (int k = DEPTH - 1; k > 0; k--) begin
                dq[k] = dq[k-1];
                vq[k] = vq[k-1];
            end
            dq[0] = dd;
            vq[0] = v;
            if (v) sb.push_back('{dd, adv_cnt + DEPTH - 1});
            last_adv = 1'b1;
        end else begin
            last_adv = 1'b0;
        end
        #1;
    endtask

    // Monitor: state checks every cycle, scoreboard pop when a new valid word is presented.
    initial begin
        int   sum;
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk) begin
                sum = 0;
                foreach (vq[i]) sum += int'(vq[i]);
                check("q_state", q, dq[DEPTH-1]);
                check("valid_out_state", vout, vq[DEPTH-1]);
                check("count", count, sum);
                check("so", so, SCAN ? dq[DEPTH-1][W-1] : 1'b0);
                if (last_adv && vout) begin
                    n_chk++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_spurious: got valid word %0h expected none at %0t", q, $time);
                    end else begin
                        e = sb.pop_front();
                        check("sb_data", q, e.data);
                        check("sb_latency", adv_cnt, e.arrive);
                    end
                end
            end
        end
    end

    initial begin
        int exp_so;
        rst = 1'b0; en = 1'b0; vin = 1'b0; d = '0; se = 1'b0; si = 1'b0;

        // Garbage state, then reset
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, W'($urandom), 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
        chk = 1'b1;
        check("rst_q", q, 0);
        check("rst_vout", vout, 0);
        check("rst_count", count, 0);
        check("rst_so", so, 0);

        // Streaming
        cyc(1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
        check("stream_first", q, 8'h11);
        check("stream_count", count, 3);
        cyc(1'b0, 1'b1, 1'b1, 8'h44, 1'b0, 1'b0);
        check("stream_second", q, 8'h22);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("stream_third", q, 8'h33);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("stream_fourth", q, 8'h44);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // Stall and bubble
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b1, W'($urandom), 1'b0, 1'b0);
            check("stall_q", q, 8'hA5);
            check("stall_count", count, 2);
        end
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("bubble_vout", vout, 0);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("after_bubble_q", q, 8'h5A);

        // Reset mid-stream
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'h12, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'h34, 1'b0, 1'b0);
        check("mid_count2", count, 2);
        cyc(1'b1, 1'b1, 1'b1, 8'h56, 1'b0, 1'b0);
        check("mid_rst_count", count, 0);
        check("mid_rst_vout", vout, 0);
        cyc(1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("fresh_q", q, 8'h77);
        check("fresh_vout", vout, 1);

        // Scan: load 0x00,0x00,0x80, then 24 shifts of SI=1 with EN toggling
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0);
        for (int n = 0; n <= W * DEPTH; n++) begin
            exp_so = (SCAN && (n == 16 || n >= W * DEPTH)) ? 1 : 0;
            check("scan_so_seq", so, exp_so);
            if (n < W * DEPTH)
                cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom), 1'b1, 1'b1);
        end
`ifdef DFF_PIPE_SCAN_EN
        check("scan_q_ff", q, 8'hFF);
        check("scan_vout_kept", vout, 1);
        check("scan_count_kept", count, 3);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("scan_stage1_ff", q, 8'hFF);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("scan_stage0_ff", q, 8'hFF);
`endif

        // Randomized traffic with occasional reset and scan
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)), W'($urandom),
                1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)));
        end
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dff_pipe.md
# dff_pipe

Parametrised successor to the single-bit master-slave `dff` cell: a WIDTH-bit, DEPTH-stage clocked pipeline register with per-stage valid tracking, stall enable, synchronous reset and an optional scan chain. It sits between combinational stdcell logic clouds as the standard register slice. It also serves as the team's scan-testable storage primitive.

## Interface
- WIDTH, 8: data bits per stage; legal range 1..64.
- DEPTH, 3: number of pipeline stages; legal range 1..16.
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset; synchronous and active-high.
- EN  in  1  advance enable; 0 = stall and hold all stages.
- D  in  WIDTH  data into stage 0.
- VALID_IN  in  1  qualifies D.
- Q  out  WIDTH  data of the last stage (DEPTH-1).
- VALID_OUT  out  1  valid bit of the last stage.
- COUNT  out  $clog2(DEPTH+1)  number of stages currently holding valid data.
- SE  in  1  scan enable.
- SI  in  1  scan serial input.
- SO  out  1  scan serial output.

## Operation
- Each stage holds `data[WIDTH]` and `valid`.
- Priority at each rising edge is RST > SE (scan builds only) > EN > hold.
- **RST=1:**
  - All stage data and valid bits clear to 0.
  - Q=0, VALID_OUT=0, COUNT=0, SO=0 from the following cycle.
- **EN=1, SE=0:**
  - Stage 0 loads D and VALID_IN.
  - Stage k loads stage k-1 for k = 1..DEPTH-1.
  - Data is captured even when VALID_IN=0; a bubble carries valid=0.
- **EN=0, SE=0:** all stages hold. Stalls may last any number of cycles.
- COUNT is registered and updated in the same edge as the valid bits:
  - it increments when VALID_IN=1 enters and the exiting stage is invalid;
  - it decrements in the opposite case;
  - otherwise it is unchanged.
  - It never exceeds DEPTH and never underflows.
- **Scan (SE=1):**
  - The chain is stage 0 bit 0 → stage 0 bit WIDTH-1 → stage 1 bit 0 … → stage DEPTH-1 bit WIDTH-1.
  - SI enters stage 0 bit 0; every data bit shifts one position per edge.
  - SO = stage DEPTH-1 bit WIDTH-1, combinationally from the register.
  - Chain length is WIDTH*DEPTH.
  - Valid bits and COUNT are frozen during scan.
  - EN is ignored while SE=1.
- Reset asserted mid-shift or mid-stream takes effect at that edge. Subsequent cycles behave as from power-on.

## Timing
- Latency is DEPTH enabled edges from D/VALID_IN to Q/VALID_OUT.
- Throughput is one word per cycle while EN=1.
- Stalled cycles add latency one-for-one.
- Q, VALID_OUT, COUNT and SO are purely register outputs with no combinational path from any input.
- For DEPTH=1 the block degenerates to a WIDTH-bit enabled register with valid.
- Scan of a full chain requires WIDTH*DEPTH edges with SE=1.

## Configuration
- Macro: `DFF_PIPE_SCAN_EN`.
- **Defined:** scan behaves as described above.
- **Undefined:**
  - SE and SI are ignored and SO is tied to 0.
  - No scan multiplexers are generated.
  - Port list is unchanged.

## Structure
- Shared package `dff_pkg`:
  - WIDTH/DEPTH legal-range constants;
  - the `stage_t` struct `{data, valid}`;
  - the COUNT width function.
- One sub-module, `dff_stage`, holds a single stage:
  - inputs CLK, RST, EN, SE, D, VALID_IN, SI;
  - outputs Q, VALID_OUT, SO.
- `dff_pipe` instantiates DEPTH copies of `dff_stage` in a generate loop.
- `dff_pipe` also owns the COUNT register.

## Test plan
All scenarios use WIDTH=8, DEPTH=3.
- **Reset:** RST=1 for 2 cycles with garbage state → Q=0x00, VALID_OUT=0, COUNT=0, SO=0.
- **Streaming:** EN=1, D=0x11,0x22,0x33,0x44 with VALID_IN=1 → Q=0x11 with VALID_OUT=1 three edges after the first, then 0x22, 0x33, 0x44 on consecutive cycles. COUNT reaches 3.
- **Stall and bubble:**
  - Send 0xA5 (valid), bubble, 0x5A, then hold EN=0 for 4 cycles.
  - Q and COUNT are frozen for the 4 cycles.
  - After EN=1, 0xA5, then VALID_OUT=0, then 0x5A emerge.
- **Reset mid-stream:** RST=1 for one cycle while COUNT=2 → next cycle COUNT=0 and VALID_OUT=0. A fresh 0x77 appears 3 edges after RST drops.
- **Scan (macro defined):**
  - Load stages with 0x80,0x00,0x00 using SE=0.
  - SE=1 and shift 24 bits with SI=1.
  - SO shows the stage-2 MSB first; the 0x80 bit of stage 0 appears on SO after 16 shifts.
  - Finally all stages read 0xFF, valid bits are unchanged, and EN is ignored throughout.
- **Scan compiled out:** the same stimulus as the previous scenario → SO stays 0 and the stages are unchanged by SE.
